// File: rtl/carfield_pkg.sv
// ----------------------------------------------------------------------------
// carfield_pkg: shared reg-bus types and register-arbiter constants.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package carfield_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } carfield_a32_d32_reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } carfield_a32_d32_reg_rsp_t;

  localparam int          CarRegArbNumReq  = 4;
  localparam int          CarRegArbTimeout = 255;
  localparam logic [31:0] CarRegArbErrData = 32'hBADC_AB1E;

endpackage

`default_nettype wire

// File: rtl/carfield_reg_arb_rr.sv
// ----------------------------------------------------------------------------
// carfield_reg_arb_rr: combinational round-robin pick, first valid at/after ptr.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module carfield_reg_arb_rr #(
  parameter int NumReq = 4
) (
  input  logic [NumReq-1:0]         valid_i,
  input  logic [$clog2(NumReq)-1:0] ptr_i,
  output logic [$clog2(NumReq)-1:0] idx_o,
  output logic                      found_o
);

  localparam int IdxW = $clog2(NumReq);

  int              pos;
  logic [IdxW-1:0] pos_idx;

  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    pos     = 0;
    pos_idx = '0;
    for (int i = 0; i < NumReq; i++) begin
      pos = int'(ptr_i) + i;
      if (pos >= NumReq) pos = pos - NumReq;
      pos_idx = IdxW'(pos);
      if (!found_o && valid_i[pos_idx]) begin
        found_o = 1'b1;
        idx_o   = pos_idx;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/carfield_reg_arb.sv
// ----------------------------------------------------------------------------
// carfield_reg_arb: round-robin N:1 reg-bus arbiter; optional target timeout
// enabled by CARFIELD_REG_ARB_TIMEOUT_EN.  Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module carfield_reg_arb import carfield_pkg::*; #(
  parameter int NumReq        = CarRegArbNumReq,
  parameter int TimeoutCycles = CarRegArbTimeout
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  carfield_a32_d32_reg_req_t [NumReq-1:0] slv_req_i,
  output carfield_a32_d32_reg_rsp_t [NumReq-1:0] slv_rsp_o,
  output carfield_a32_d32_reg_req_t              mst_req_o,
  input  carfield_a32_d32_reg_rsp_t              mst_rsp_i,
  output logic [$clog2(NumReq)-1:0]              gnt_idx_o,
  output logic                                   busy_o,
  output logic                                   timeout_o
);

  localparam int IdxW = $clog2(NumReq);

  if (NumReq < 2 || NumReq > 8 || TimeoutCycles < 2) begin : g_param_check
    $error("carfield_reg_arb: illegal NumReq or TimeoutCycles");
  end

`ifdef CARFIELD_REG_ARB_TIMEOUT_EN
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, TO_RSP = 2'd2} state_e;
  localparam int CntW = $clog2(TimeoutCycles + 1);
  logic [CntW-1:0] cnt_q;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1} state_e;
`endif

  state_e          state_q;
  logic [IdxW-1:0] rr_ptr_q;
  logic [IdxW-1:0] gnt_q;
  logic [IdxW-1:0] rr_next_d;
  logic [IdxW-1:0] pick_idx;
  logic            pick_found;
  logic [NumReq-1:0] req_valid;
  logic            hs;

  always_comb begin
    req_valid = '0;
    for (int k = 0; k < NumReq; k++) req_valid[k] = slv_req_i[k].valid;
  end

  carfield_reg_arb_rr #(.NumReq(NumReq)) u_rr (
    .valid_i (req_valid),
    .ptr_i   (rr_ptr_q),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  assign hs        = slv_req_i[gnt_q].valid & mst_rsp_i.ready;
  assign rr_next_d = (gnt_q == IdxW'(NumReq - 1)) ? '0 : gnt_q + 1'b1;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      gnt_q    <= '0;
`ifdef CARFIELD_REG_ARB_TIMEOUT_EN
      cnt_q    <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_found) begin
            gnt_q   <= pick_idx;
            state_q <= BUSY;
`ifdef CARFIELD_REG_ARB_TIMEOUT_EN
            cnt_q   <= '0;
`endif
          end
        end
        BUSY: begin
          // A completed handshake wins over a timeout hitting the same cycle.
          if (hs) begin
            rr_ptr_q <= rr_next_d;
            state_q  <= IDLE;
          end else if (!slv_req_i[gnt_q].valid) begin
            state_q  <= IDLE;
`ifdef CARFIELD_REG_ARB_TIMEOUT_EN
          end else if (cnt_q == CntW'(TimeoutCycles - 1)) begin
            state_q  <= TO_RSP;
          end else begin
            cnt_q    <= cnt_q + 1'b1;
`endif
          end
        end
`ifdef CARFIELD_REG_ARB_TIMEOUT_EN
        TO_RSP: begin
          rr_ptr_q <= rr_next_d;
          state_q  <= IDLE;
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    mst_req_o = '0;
    slv_rsp_o = '0;
    case (state_q)
      BUSY: begin
        mst_req_o        = slv_req_i[gnt_q];
        slv_rsp_o[gnt_q] = mst_rsp_i;
      end
`ifdef CARFIELD_REG_ARB_TIMEOUT_EN
      TO_RSP: begin
        slv_rsp_o[gnt_q].ready = 1'b1;
        slv_rsp_o[gnt_q].error = 1'b1;
        slv_rsp_o[gnt_q].rdata = CarRegArbErrData;
      end
`endif
      default: ;
    endcase
  end

  assign gnt_idx_o = gnt_q;
  assign busy_o    = (state_q != IDLE);
`ifdef CARFIELD_REG_ARB_TIMEOUT_EN
  assign timeout_o = (state_q == TO_RSP);
`else
  assign timeout_o = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_carfield_reg_arb.sv
// ----------------------------------------------------------------------------
// tb_carfield_reg_arb: scoreboard bench for the round-robin reg-bus arbiter.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_carfield_reg_arb;
  import carfield_pkg::*;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst;
  carfield_a32_d32_reg_req_t [N-1:0] slv_req;
  carfield_a32_d32_reg_rsp_t [N-1:0] slv_rsp;
  carfield_a32_d32_reg_req_t         mst_req;
  carfield_a32_d32_reg_rsp_t         mst_rsp;
  logic [1:0] gnt_idx;
  logic       busy;
  logic       timeout;
  logic       tgt_ready;
  logic       tgt_err;

  typedef struct {
    int          idx;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   to_pulses = 0;

  always #5 clk = ~clk;

  carfield_reg_arb #(.NumReq(N), .TimeoutCycles(4)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .slv_req_i (slv_req),
    .slv_rsp_o (slv_rsp),
    .mst_req_o (mst_req),
    .mst_rsp_i (mst_rsp),
    .gnt_idx_o (gnt_idx),
    .busy_o    (busy),
    .timeout_o (timeout)
  );

  // Behavioural target: read data is the inverted request address.
  always_comb begin
    mst_rsp.rdata = ~mst_req.addr;
    mst_rsp.ready = tgt_ready;
    mst_rsp.error = tgt_err;
  end

  function automatic logic [31:0] inv_addr(input int k);
    case (k)
      0:       return 32'hDFFE_FEFF;
      1:       return 32'hDFFE_FDFF;
      2:       return 32'hDFFE_FFFF;
      default: return 32'hDFFE_FCFF;
    endcase
  endfunction

  task automatic push(input int idx, input logic [31:0] rd, input logic er);
    exp_t e;
    e.idx = idx; e.rdata = rd; e.err = er;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every response presented to a requester is matched against the queue.
  always @(negedge clk) begin
    if (timeout === 1'b1) to_pulses++;
    for (int k = 0; k < N; k++) begin
      if (slv_rsp[k].ready === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_rsp slot=%0d rdata=%h", k, slv_rsp[k].rdata);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (k != e.idx || slv_rsp[k].rdata !== e.rdata || slv_rsp[k].error !== e.err) begin
            errors++;
            $display("FAIL rsp_check slot=%0d/%0d rdata=%h/%h err=%b/%b (actual/required)",
                     k, e.idx, slv_rsp[k].rdata, e.rdata, slv_rsp[k].error, e.err);
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1; tgt_ready = 1'b0; tgt_err = 1'b0;
    for (int k = 0; k < N; k++) begin
      slv_req[k].write = 1'b1;
      slv_req[k].wdata = 32'hC0DE_0000 + k;
      slv_req[k].wstrb = 4'hF;
      slv_req[k].valid = 1'b0;
    end
    slv_req[0].addr = 32'h2001_0100;
    slv_req[1].addr = 32'h2001_0200;
    slv_req[2].addr = 32'h2001_0000;
    slv_req[3].addr = 32'h2001_0300;
    slv_req[1].valid = 1'b1;

    // Reset holds everything quiet even with a pending request.
    repeat (3) @(posedge clk); #1;
    chk("rst_mst_valid", 32'(mst_req.valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_timeout", 32'(timeout), 0);
    chk("rst_gnt", 32'(gnt_idx), 0);
    chk("rst_slv_ready", {28'd0, slv_rsp[3].ready, slv_rsp[2].ready, slv_rsp[1].ready, slv_rsp[0].ready}, 0);
    slv_req[1].valid = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;

    // Single requester, two back-to-back writes.
    push(2, 32'hDFFE_FFFF, 1'b0);
    push(2, 32'hDFFE_FFFF, 1'b0);
    tgt_ready = 1'b1;
    slv_req[2].valid = 1'b1;
    @(posedge clk); #1;
    chk("s1_gnt", 32'(gnt_idx), 2);
    chk("s1_busy", 32'(busy), 1);
    chk("s1_mst_addr", mst_req.addr, 32'h2001_0000);
    repeat (3) @(posedge clk); #1;
    slv_req[2].valid = 1'b0;
    chk("s1_gnt_hold", 32'(gnt_idx), 2);
    chk("s1_idle", 32'(busy), 0);
    @(posedge clk); #1;
    chk("s1_q_empty", exp_q.size(), 0);

    // Pointer now at 3: requester 1 wins before 2.
    push(1, 32'hDFFE_FDFF, 1'b0);
    push(2, 32'hDFFE_FFFF, 1'b0);
    slv_req[1].valid = 1'b1;
    slv_req[2].valid = 1'b1;
    repeat (4) @(posedge clk); #1;
    slv_req[1].valid = 1'b0;
    slv_req[2].valid = 1'b0;
    @(posedge clk); #1;
    chk("s3_q_empty", exp_q.size(), 0);

    // All requesters continuously valid from a fresh pointer.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < N; k++) slv_req[k].valid = 1'b1;
    push(0, inv_addr(0), 1'b0);
    push(1, inv_addr(1), 1'b0);
    push(2, inv_addr(2), 1'b0);
    push(3, inv_addr(3), 1'b0);
    push(0, inv_addr(0), 1'b0);
    repeat (10) @(posedge clk); #1;
    for (int k = 0; k < N; k++) slv_req[k].valid = 1'b0;
    @(posedge clk); #1;
    chk("s2_q_empty", exp_q.size(), 0);

`ifdef CARFIELD_REG_ARB_TIMEOUT_EN
    // Target never ready: four BUSY cycles then one TO_RSP cycle.
    tgt_ready = 1'b0;
    slv_req[3].valid = 1'b1;
    push(3, 32'hBADC_AB1E, 1'b1);
    repeat (5) @(posedge clk); #1;
    chk("to_pulse_now", 32'(timeout), 1);
    chk("to_busy", 32'(busy), 1);
    @(posedge clk); #1;
    slv_req[3].valid = 1'b0;
    chk("to_pulse_end", 32'(timeout), 0);
    chk("to_idle", 32'(busy), 0);

    // Ready arrives on the limit cycle: normal response wins.
    tgt_err = 1'b1;
    slv_req[0].valid = 1'b1;
    push(0, inv_addr(0), 1'b1);
    repeat (4) @(posedge clk); #1;
    chk("lim_busy", 32'(busy), 1);
    tgt_ready = 1'b1;
    @(posedge clk); #1;
    slv_req[0].valid = 1'b0;
    tgt_ready = 1'b0;
    tgt_err = 1'b0;
    chk("lim_idle", 32'(busy), 0);
    @(posedge clk); #1;
    chk("to_q_empty", exp_q.size(), 0);
    chk("to_pulse_count", to_pulses, 1);
`else
    // Without the timeout the arbiter waits; dropping valid releases it.
    tgt_ready = 1'b0;
    slv_req[3].valid = 1'b1;
    repeat (10) @(posedge clk); #1;
    chk("wait_busy", 32'(busy), 1);
    chk("wait_gnt", 32'(gnt_idx), 3);
    slv_req[3].valid = 1'b0;
    @(posedge clk); #1;
    chk("drop_idle", 32'(busy), 0);
    chk("no_timeout", to_pulses, 0);
`endif

    // Reset in the middle of a transfer.
    tgt_ready = 1'b0;
    slv_req[2].valid = 1'b1;
    @(posedge clk); #1;
    chk("mid_mst_valid", 32'(mst_req.valid), 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_valid", 32'(mst_req.valid), 0);
    chk("rst_async_busy", 32'(busy), 0);
    chk("rst_async_gnt", 32'(gnt_idx), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    slv_req[0].valid = 1'b1;
    tgt_ready = 1'b1;
    push(0, inv_addr(0), 1'b0);
    push(2, inv_addr(2), 1'b0);
    repeat (4) @(posedge clk); #1;
    slv_req[0].valid = 1'b0;
    slv_req[2].valid = 1'b0;
    @(posedge clk); #1;
    chk("rst_q_empty", exp_q.size(), 0);

    repeat (2) @(posedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/carfield_reg_arb.md
CARFIELD_REG_ARB -- requirements
Module: carfield_reg_arb

Interface
REQ-001 SHALL have parameter NumReq, default 4: number of requesters; legal range 2..8.
REQ-002 SHALL have parameter TimeoutCycles, default 255: target-wait limit in cycles; minimum 2.
REQ-003 SHALL have port clk_i, input, 1 bit: single clock, rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit: reset, asynchronous assert, active-high.
REQ-005 SHALL have port slv_req_i, input, NumReq x carfield_a32_d32_reg_req_t: requester reg-bus requests.
REQ-006 SHALL have port slv_rsp_o, output, NumReq x carfield_a32_d32_reg_rsp_t: requester responses.
REQ-007 SHALL have port mst_req_o, output, carfield_a32_d32_reg_req_t: request to the shared target.
REQ-008 SHALL have port mst_rsp_i, input, carfield_a32_d32_reg_rsp_t: target response.
REQ-009 SHALL have port gnt_idx_o, output, $clog2(NumReq) bits: index of the current owner.
REQ-010 SHALL have port busy_o, output, 1 bit: high in BUSY and TO_RSP.
REQ-011 SHALL have port timeout_o, output, 1 bit: one-cycle pulse on a timed-out transfer.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY and TO_RSP.
- IDLE with any slv_req_i[k].valid: pick the first valid index at or after rr_ptr, wrapping modulo NumReq.
- Register the pick into gnt_idx.
- Go to BUSY next cycle; arbitration costs exactly 1 cycle.
REQ-013 SHALL, in IDLE, drive mst_req_o.valid=0 and all slv_rsp_o ready=0, rdata=0, error=0.
REQ-014 SHALL, in BUSY, forward combinationally:
- mst_req_o = slv_req_i[gnt_idx].
- slv_rsp_o[gnt_idx] = mst_rsp_i.
- Non-granted slv_rsp_o stay all-zero.
REQ-015 SHALL, on a BUSY handshake (mst valid and mst_rsp_i.ready), set rr_ptr=(gnt_idx+1) mod NumReq and go to IDLE.
REQ-016 SHALL, when the granted requester drops valid in BUSY before ready, go to IDLE without changing rr_ptr.
REQ-017 SHALL ignore requests that arrive while in BUSY or TO_RSP, leaving their ready low, until the next IDLE arbitration.
REQ-018 SHALL give a minimum of 2 cycles per transfer and a worst-case wait of NumReq-1 foreign transfers (starvation-free).
REQ-019 SHALL hold gnt_idx_o at its last value in IDLE.

Reset
REQ-020 SHALL, while rst_i is high:
- Hold state=IDLE, rr_ptr=0, gnt_idx=0 and timeout counter=0.
- Drive busy_o=0, timeout_o=0, mst_req_o all-zero and slv_rsp_o all-zero.
REQ-021 SHALL, on reset mid-BUSY, drop mst_req_o.valid immediately (asynchronously) and give no response to the interrupted requester.

Configuration
REQ-022 SHALL implement the timeout feature when CARFIELD_REG_ARB_TIMEOUT_EN is defined.
- A counter of $clog2(TimeoutCycles+1) bits clears on BUSY entry.
- It increments each BUSY cycle without a handshake.
- When it equals TimeoutCycles-1 without a handshake, the FSM goes to TO_RSP.
REQ-023 SHALL, in TO_RSP (exactly one cycle), drive:
- mst_req_o.valid=0.
- slv_rsp_o[gnt_idx] ready=1, error=1, rdata=32'hBADC_AB1E.
- timeout_o=1.
It SHALL then set rr_ptr=gnt_idx+1 mod NumReq and go to IDLE.
REQ-024 SHALL, without CARFIELD_REG_ARB_TIMEOUT_EN:
- Omit the counter and the TO_RSP state.
- Wait in BUSY indefinitely.
- Tie timeout_o to 0.
TimeoutCycles SHALL then be unused.
REQ-025 SHALL, when a handshake and the timeout limit occur in the same cycle, take the handshake (REQ-015) with priority.

Structure
REQ-026 SHALL take carfield_a32_d32_reg_req_t/rsp_t from carfield_pkg.
REQ-027 SHALL add to carfield_pkg: CarRegArbNumReq=4, CarRegArbTimeout=255 and CarRegArbErrData=32'hBADC_AB1E.
REQ-028 SHALL place the priority pick (valid vector plus rr_ptr giving an index and found flag) in sub-module carfield_reg_arb_rr, which is purely combinational.

Verification
REQ-029 SHALL cover: single requester 2 writes addr 0x2001_0000, target ready same cycle -> each completes 2 cycles after valid, gnt_idx_o=2, rr_ptr 3 after each.
REQ-030 SHALL cover: all 4 requesters valid continuously, target always ready -> grant order 0,1,2,3,0, one transfer per 2 cycles.
REQ-031 SHALL cover: rr_ptr=3, requesters 1 and 2 valid -> 1 granted first, then 2.
REQ-032 SHALL cover: timeout enabled, TimeoutCycles=4, target never ready -> TO_RSP on 4th BUSY cycle, error=1, rdata=0xBADCAB1E, timeout_o one pulse.
REQ-033 SHALL cover: target ready on the same cycle as the timeout limit -> normal response, error=mst_rsp_i.error, timeout_o=0.
REQ-034 SHALL cover: rst_i asserted mid-BUSY -> mst_req_o.valid=0 same cycle, busy_o=0, first grant after release goes to index 0.
